// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo datapath constants and the reorder-buffer entry layout.
package tomasulo_pkg;

  localparam int DATA_W = 16;
  localparam int REG_W  = 3;
  localparam int TAG_W  = 4;

  localparam logic [TAG_W-1:0]  TAG_NONE  = 4'd0;
  localparam logic [DATA_W-1:0] SEM_VALOR = 16'hFFF0;

  typedef struct packed {
    logic              busy;
    logic              ready;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] value;
  } rob_entry_t;

  // Entry i is published as tag i+1 so that tag 0 can mean "no producer".
  function automatic logic [TAG_W-1:0] idx_to_tag(input logic [TAG_W-1:0] idx);
    return idx + 4'd1;
  endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// Dispatch, CDB and commit signals of the reorder buffer; lookup ports under ROB_LOOKUP_EN.
interface reorder_buffer_if;
  import tomasulo_pkg::*;

  logic              Alloc_req;
  logic [REG_W-1:0]  Alloc_rd;
  logic [TAG_W-1:0]  Alloc_tag;
  logic              Full;
  logic              Empty;
  logic [TAG_W-1:0]  Count;
  logic              Cdb_valid;
  logic [TAG_W-1:0]  Cdb_tag;
  logic [DATA_W-1:0] Cdb_data;
  logic              Commit_valid;
  logic [TAG_W-1:0]  Commit_tag;
  logic [REG_W-1:0]  Commit_rd;
  logic [DATA_W-1:0] Commit_data;
`ifdef ROB_LOOKUP_EN
  logic [TAG_W-1:0]  Look_tag_j;
  logic [TAG_W-1:0]  Look_tag_k;
  logic              Look_ready_j;
  logic              Look_ready_k;
  logic [DATA_W-1:0] Look_data_j;
  logic [DATA_W-1:0] Look_data_k;
`endif

  modport master (
    output Alloc_req, Alloc_rd, Cdb_valid, Cdb_tag, Cdb_data,
`ifdef ROB_LOOKUP_EN
    output Look_tag_j, Look_tag_k,
    input  Look_ready_j, Look_ready_k, Look_data_j, Look_data_k,
`endif
    input  Alloc_tag, Full, Empty, Count,
    input  Commit_valid, Commit_tag, Commit_rd, Commit_data
  );

  modport slave (
    input  Alloc_req, Alloc_rd, Cdb_valid, Cdb_tag, Cdb_data,
`ifdef ROB_LOOKUP_EN
    input  Look_tag_j, Look_tag_k,
    output Look_ready_j, Look_ready_k, Look_data_j, Look_data_k,
`endif
    output Alloc_tag, Full, Empty, Count,
    output Commit_valid, Commit_tag, Commit_rd, Commit_data
  );

endinterface

// File: rtl/reorder_buffer_ptr.sv
// rob_ptr: modulo-DEPTH pointer used for the reorder buffer head and tail.
module rob_ptr #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr
);

  localparam logic [PTR_W-1:0] LAST_C = PTR_W'(DEPTH - 1);

  // Advance and wrap from DEPTH-1 back to entry 0.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      ptr <= {PTR_W{1'b0}};
    end else if (inc) begin
      ptr <= (ptr == LAST_C) ? {PTR_W{1'b0}} : ptr + PTR_W'(1);
    end else begin
      ptr <= ptr;
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// In-order commit reorder buffer: allocates tags, captures CDB results, retires in program order.
// Optional combinational operand lookup ports are enabled with `define ROB_LOOKUP_EN.
module reorder_buffer
  import tomasulo_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic             Clock,
  input logic             Reset,
  reorder_buffer_if.slave bus
);

  localparam int               IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [TAG_W-1:0] DEPTH_C = TAG_W'(DEPTH);

  rob_entry_t        entries_r [DEPTH];
  logic [TAG_W-1:0]  count_r;
  logic [TAG_W-1:0]  head_s;
  logic [TAG_W-1:0]  tail_s;
  rob_entry_t        head_entry_s;
  logic              full_s;
  logic              alloc_s;
  logic              commit_s;
  logic              commit_valid_r;
  logic [TAG_W-1:0]  commit_tag_r;
  logic [REG_W-1:0]  commit_rd_r;
  logic [DATA_W-1:0] commit_data_r;

  assign full_s       = (count_r == DEPTH_C);
  assign head_entry_s = entries_r[head_s[IDX_W-1:0]];
  assign alloc_s      = bus.Alloc_req && !full_s;
  // Ready must already be set before this edge, so a same-edge CDB hit never commits.
  assign commit_s     = head_entry_s.busy && head_entry_s.ready;

  rob_ptr #(.DEPTH(DEPTH), .PTR_W(TAG_W)) u_head (
    .Clock(Clock), .Reset(Reset), .inc(commit_s), .ptr(head_s)
  );

  rob_ptr #(.DEPTH(DEPTH), .PTR_W(TAG_W)) u_tail (
    .Clock(Clock), .Reset(Reset), .inc(alloc_s), .ptr(tail_s)
  );

  // Per-entry allocate / capture / retire; the three never target the same entry on one edge.
  always_ff @(posedge Clock) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (Reset) begin
        entries_r[i] <= '0;
      end else if (alloc_s && tail_s == TAG_W'(i)) begin
        entries_r[i].busy  <= 1'b1;
        entries_r[i].ready <= 1'b0;
        entries_r[i].rd    <= bus.Alloc_rd;
        entries_r[i].value <= {DATA_W{1'b0}};
      end else if (bus.Cdb_valid && bus.Cdb_tag == idx_to_tag(TAG_W'(i))
                   && entries_r[i].busy && !entries_r[i].ready) begin
        entries_r[i].ready <= 1'b1;
        entries_r[i].value <= bus.Cdb_data;
      end else if (commit_s && head_s == TAG_W'(i)) begin
        entries_r[i].busy  <= 1'b0;
        entries_r[i].ready <= 1'b0;
      end else begin
        entries_r[i] <= entries_r[i];
      end
    end
  end

  // Occupancy counter; Full/Empty derive from it rather than from the pointers.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      count_r <= {TAG_W{1'b0}};
    end else begin
      count_r <= count_r + TAG_W'(alloc_s) - TAG_W'(commit_s);
    end
  end

  // Registered commit port; payload holds its last value between pulses.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      commit_valid_r <= 1'b0;
      commit_tag_r   <= TAG_NONE;
      commit_rd_r    <= {REG_W{1'b0}};
      commit_data_r  <= {DATA_W{1'b0}};
    end else if (commit_s) begin
      commit_valid_r <= 1'b1;
      commit_tag_r   <= idx_to_tag(head_s);
      commit_rd_r    <= head_entry_s.rd;
      commit_data_r  <= head_entry_s.value;
    end else begin
      commit_valid_r <= 1'b0;
    end
  end

  assign bus.Alloc_tag    = idx_to_tag(tail_s);
  assign bus.Full         = full_s;
  assign bus.Empty        = (count_r == {TAG_W{1'b0}});
  assign bus.Count        = count_r;
  assign bus.Commit_valid = commit_valid_r;
  assign bus.Commit_tag   = commit_tag_r;
  assign bus.Commit_rd    = commit_rd_r;
  assign bus.Commit_data  = commit_data_r;

`ifdef ROB_LOOKUP_EN
  // Forward completed-but-uncommitted values to dispatch operand reads.
  always_comb begin
    bus.Look_ready_j = 1'b0;
    bus.Look_ready_k = 1'b0;
    bus.Look_data_j  = SEM_VALOR;
    bus.Look_data_k  = SEM_VALOR;
    for (int i = 0; i < DEPTH; i++) begin
      bus.Look_ready_j = bus.Look_ready_j | (bus.Look_tag_j == idx_to_tag(TAG_W'(i))
                         && entries_r[i].busy && entries_r[i].ready);
      bus.Look_data_j  = (bus.Look_tag_j == idx_to_tag(TAG_W'(i)) && entries_r[i].busy
                         && entries_r[i].ready) ? entries_r[i].value : bus.Look_data_j;
      bus.Look_ready_k = bus.Look_ready_k | (bus.Look_tag_k == idx_to_tag(TAG_W'(i))
                         && entries_r[i].busy && entries_r[i].ready);
      bus.Look_data_k  = (bus.Look_tag_k == idx_to_tag(TAG_W'(i)) && entries_r[i].busy
                         && entries_r[i].ready) ? entries_r[i].value : bus.Look_data_k;
    end
  end
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: scoreboard of expected commits plus per-scenario checks.
module tb_reorder_buffer;
  import tomasulo_pkg::*;

  typedef struct {
    logic [TAG_W-1:0]  tag;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic Clock = 1'b0;
  logic Reset;
  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];
  exp_t got_e;

  always #5 Clock = ~Clock;

  reorder_buffer_if bus ();

  reorder_buffer #(.DEPTH(4)) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (bus)
  );

  // Scoreboard: every commit pulse must match the oldest expected entry.
  always @(negedge Clock) begin
    if (bus.Commit_valid === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_commit got tag=%0d rd=%0d data=%h want none",
                 bus.Commit_tag, bus.Commit_rd, bus.Commit_data);
      end else begin
        got_e = exp_q.pop_front();
        if (bus.Commit_tag !== got_e.tag || bus.Commit_rd !== got_e.rd ||
            bus.Commit_data !== got_e.data) begin
          bad++;
          $display("FAIL commit_payload got tag=%0d rd=%0d data=%h want tag=%0d rd=%0d data=%h",
                   bus.Commit_tag, bus.Commit_rd, bus.Commit_data, got_e.tag, got_e.rd, got_e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle();
    bus.Alloc_req = 1'b0;
    bus.Alloc_rd  = 3'd0;
    bus.Cdb_valid = 1'b0;
    bus.Cdb_tag   = 4'd0;
    bus.Cdb_data  = 16'h0000;
`ifdef ROB_LOOKUP_EN
    bus.Look_tag_j = 4'd0;
    bus.Look_tag_k = 4'd0;
`endif
  endtask

  task automatic do_reset();
    idle();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
  endtask

  task automatic alloc(input logic [REG_W-1:0] rd);
    bus.Alloc_req = 1'b1;
    bus.Alloc_rd  = rd;
    tick();
    bus.Alloc_req = 1'b0;
  endtask

  task automatic cdb(input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] data);
    bus.Cdb_valid = 1'b1;
    bus.Cdb_tag   = tag;
    bus.Cdb_data  = data;
    tick();
    bus.Cdb_valid = 1'b0;
  endtask

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    do_reset();
    chk("reset_count", int'(bus.Count), 0);
    chk("reset_empty", int'(bus.Empty), 1);
    chk("reset_full", int'(bus.Full), 0);
    chk("reset_commit_valid", int'(bus.Commit_valid), 0);
    chk("reset_commit_tag", int'(bus.Commit_tag), 0);
    chk("reset_alloc_tag", int'(bus.Alloc_tag), 1);
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      chk("fill_alloc_tag", int'(bus.Alloc_tag), i + 1);
      alloc(3'(i + 1));
    end
    chk("fill_full", int'(bus.Full), 1);
    chk("fill_count", int'(bus.Count), 4);
    alloc(3'd5);
    chk("fill_overflow_count", int'(bus.Count), 4);
    chk("fill_overflow_empty", int'(bus.Empty), 0);
  endtask

  task automatic test_single();
    do_reset();
    alloc(3'd2);
    exp_q.push_back('{tag: 4'd1, rd: 3'd2, data: 16'h0005});
    cdb(4'd1, 16'h0005);
    chk("single_no_early_commit", int'(bus.Commit_valid), 0);
    tick();
    chk("single_commit_valid", int'(bus.Commit_valid), 1);
    chk("single_commit_tag", int'(bus.Commit_tag), 1);
    chk("single_empty_after", int'(bus.Empty), 1);
    tick();
    chk("single_pulse_one_cycle", int'(bus.Commit_valid), 0);
    chk("single_tag_holds", int'(bus.Commit_tag), 1);
  endtask

  task automatic test_out_of_order();
    do_reset();
    alloc(3'd5);
    alloc(3'd6);
    exp_q.push_back('{tag: 4'd1, rd: 3'd5, data: 16'h0010});
    exp_q.push_back('{tag: 4'd2, rd: 3'd6, data: 16'h0030});
    cdb(4'd2, 16'h0030);
    tick();
    chk("ooo_head_blocks", int'(bus.Commit_valid), 0);
    cdb(4'd1, 16'h0010);
    chk("ooo_no_same_edge", int'(bus.Commit_valid), 0);
    tick();
    chk("ooo_first_tag", int'(bus.Commit_tag), 1);
    tick();
    chk("ooo_second_valid", int'(bus.Commit_valid), 1);
    chk("ooo_second_tag", int'(bus.Commit_tag), 2);
    tick();
    chk("ooo_empty", int'(bus.Empty), 1);
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back('{tag: 4'(i + 1), rd: 3'(i + 1), data: 16'(16'h0100 + i)});
      alloc(3'(i + 1));
    end
    cdb(4'd1, 16'h0100);
    chk("wrap_full_before", int'(bus.Full), 1);
    bus.Alloc_req = 1'b1;
    bus.Alloc_rd  = 3'd7;
    tick();
    chk("wrap_refused_count", int'(bus.Count), 3);
    chk("wrap_commit_valid", int'(bus.Commit_valid), 1);
    chk("wrap_alloc_tag", int'(bus.Alloc_tag), 1);
    exp_q.push_back('{tag: 4'd1, rd: 3'd7, data: 16'h0777});
    tick();
    bus.Alloc_req = 1'b0;
    chk("wrap_accepted_count", int'(bus.Count), 4);
    chk("wrap_full_again", int'(bus.Full), 1);
    cdb(4'd2, 16'h0101);
    cdb(4'd3, 16'h0102);
    cdb(4'd4, 16'h0103);
    cdb(4'd1, 16'h0777);
    for (int i = 0; i < 3; i++) tick();
    chk("wrap_drained_count", int'(bus.Count), 0);
    chk("wrap_drained_empty", int'(bus.Empty), 1);
  endtask

  task automatic test_ignored_cdb();
    do_reset();
    alloc(3'd3);
    alloc(3'd4);
    cdb(4'd0, 16'h1234);
    cdb(4'd6, 16'h5678);
    tick();
    chk("ign_no_commit", int'(bus.Commit_valid), 0);
    chk("ign_count", int'(bus.Count), 2);
    exp_q.push_back('{tag: 4'd1, rd: 3'd3, data: 16'h0011});
    exp_q.push_back('{tag: 4'd2, rd: 3'd4, data: 16'h0055});
    cdb(4'd2, 16'h0055);
    cdb(4'd2, 16'h0099);
    chk("ign_repeat_no_commit", int'(bus.Commit_valid), 0);
    cdb(4'd1, 16'h0011);
    for (int i = 0; i < 3; i++) tick();
    chk("ign_empty", int'(bus.Empty), 1);
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 4; i++) alloc(3'(i + 1));
    cdb(4'd2, 16'h0202);
    cdb(4'd3, 16'h0203);
    cdb(4'd4, 16'h0204);
    chk("mid_pending_count", int'(bus.Count), 4);
`ifdef ROB_LOOKUP_EN
    bus.Look_tag_j = 4'd3;
    bus.Look_tag_k = 4'd1;
    #1;
    chk("look_ready_hit", int'(bus.Look_ready_j), 1);
    chk("look_data_hit", int'(bus.Look_data_j), 16'h0203);
    chk("look_ready_busy_not_ready", int'(bus.Look_ready_k), 0);
    chk("look_data_not_ready", int'(bus.Look_data_k), 16'hFFF0);
`endif
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("mid_commit_valid", int'(bus.Commit_valid), 0);
    chk("mid_count", int'(bus.Count), 0);
    chk("mid_empty", int'(bus.Empty), 1);
`ifdef ROB_LOOKUP_EN
    chk("look_ready_after_reset", int'(bus.Look_ready_j), 0);
    chk("look_data_after_reset", int'(bus.Look_data_j), 16'hFFF0);
`endif
    cdb(4'd1, 16'h0201);
    for (int i = 0; i < 3; i++) begin
      chk("mid_no_stale_commit", int'(bus.Commit_valid), 0);
      tick();
    end
    idle();
  endtask

  initial begin
    Reset = 1'b1;
    idle();
    test_reset();
    test_fill();
    test_single();
    test_out_of_order();
    test_full_wrap();
    test_ignored_cdb();
    test_reset_mid();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
